debug_display_scheduler: RTL and testbench

- Time-shares the 4x8 LED debug display between N_SRC debug sources, each presenting a 32-bit word.
- Rotates through valid sources on a dwell timer, on a user advance pulse, or on an urgent preempt.
- Drives the four 8-bit column inputs of the LED strobe driver and sits directly upstream of it, in the icefun top level.

---
 rtl/debug_display_pkg.sv | 21 ++
 rtl/rr_next_valid.sv | 28 ++
 rtl/debug_display_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_debug_display_scheduler.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/debug_display_pkg.sv
// Shared types and constants for the LED debug display scheduler.
package debug_display_pkg;

  localparam int SRC_W = 32;

  localparam int COL1_MSB = 31;
  localparam int COL1_LSB = 24;
  localparam int COL2_MSB = 23;
  localparam int COL2_LSB = 16;
  localparam int COL3_MSB = 15;
  localparam int COL3_LSB = 8;
  localparam int COL4_MSB = 7;
  localparam int COL4_LSB = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW   = 2'd1,
    URGENT = 2'd2
  } state_e;

endpackage

// File: rtl/rr_next_valid.sv
// Round-robin search: first valid index after base_i with wrap-around, base_i itself last.
module rr_next_valid #(
  parameter int N_SRC = 4,
  parameter int IW    = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] valid_i,
  input  logic [IW-1:0]    base_i,
  output logic             found_o,
  output logic [IW-1:0]    idx_o
);

  logic [IW-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest hit is written last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      cand = IW'((int'(base_i) + k) % N_SRC);
      if (valid_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/debug_display_scheduler.sv
// Time-shares the 4x8 LED debug display between N_SRC sources (rotation, advance, urgent preempt).
// Optional build macro DEBUG_DISPLAY_SNAPSHOT_EN: capture the word once per selection instead of live.
module debug_display_scheduler
  import debug_display_pkg::*;
#(
  parameter int N_SRC         = 4,
  parameter int DWELL_CYCLES  = 12000000,
  parameter int URGENT_CYCLES = 24000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_SRC*SRC_W-1:0]   src_data,
  input  logic [N_SRC-1:0]         src_valid,
  input  logic [N_SRC-1:0]         src_urgent,
  input  logic                     advance,
  output logic [7:0]               column_1,
  output logic [7:0]               column_2,
  output logic [7:0]               column_3,
  output logic [7:0]               column_4,
  output logic [$clog2(N_SRC)-1:0] active_src,
  output logic                     showing
);

  localparam int IW = $clog2(N_SRC);
  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int UW = (URGENT_CYCLES > 1) ? $clog2(URGENT_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST  = DW'(DWELL_CYCLES - 1);
  localparam logic [UW-1:0] URGENT_LAST = UW'(URGENT_CYCLES - 1);

`ifdef DEBUG_DISPLAY_SNAPSHOT_EN
  localparam bit LIVE = 1'b0;
`else
  localparam bit LIVE = 1'b1;
`endif

  state_e           state_q, state_d;
  logic [IW-1:0]    active_q, active_d;
  logic [IW-1:0]    resume_q, resume_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [UW-1:0]    ucnt_q, ucnt_d;
  logic [N_SRC-1:0] urg_q;
  logic [SRC_W-1:0] word_q;
  logic             showing_q;

  logic [SRC_W-1:0] words [N_SRC];
  logic [N_SRC-1:0] urg_lvl;
  logic [N_SRC-1:0] urg_edge;
  logic             urg_any;
  logic [IW-1:0]    urg_idx;
  logic             nv_act_found, nv_res_found;
  logic [IW-1:0]    nv_act_idx, nv_res_idx;
  logic             rotate;
  logic             select;

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_words
      assign words[gi] = src_data[gi*SRC_W +: SRC_W];
    end
  endgenerate

  // An urgent request only counts while its source is valid.
  assign urg_lvl  = src_urgent & src_valid;
  assign urg_edge = urg_lvl & ~urg_q;
  assign urg_any  = |urg_edge;

  always_comb begin
    urg_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (urg_edge[i]) urg_idx = IW'(i);
    end
  end

  rr_next_valid #(.N_SRC(N_SRC), .IW(IW)) u_nv_act (
    .valid_i (src_valid),
    .base_i  (active_q),
    .found_o (nv_act_found),
    .idx_o   (nv_act_idx)
  );

  rr_next_valid #(.N_SRC(N_SRC), .IW(IW)) u_nv_res (
    .valid_i (src_valid),
    .base_i  (resume_q),
    .found_o (nv_res_found),
    .idx_o   (nv_res_idx)
  );

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    resume_d = resume_q;
    dwell_d  = dwell_q;
    ucnt_d   = ucnt_q;
    rotate   = 1'b0;
    select   = 1'b0;

    if (urg_any) begin
      // Retargeting inside URGENT keeps the original place to come back to.
      if (state_q != URGENT) resume_d = active_q;
      state_d  = URGENT;
      active_d = urg_idx;
      ucnt_d   = '0;
      select   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|src_valid) rotate = 1'b1;
        end
        SHOW: begin
          if (advance || !src_valid[active_q] || dwell_q == DWELL_LAST) begin
            rotate = 1'b1;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
        URGENT: begin
          if (advance) begin
            rotate = 1'b1;
          end else if (!src_valid[active_q] || ucnt_q == URGENT_LAST) begin
            dwell_d = '0;
            if (src_valid[resume_q]) begin
              state_d  = SHOW;
              active_d = resume_q;
              select   = 1'b1;
            end else if (nv_res_found) begin
              state_d  = SHOW;
              active_d = nv_res_idx;
              select   = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            ucnt_d = ucnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (rotate) begin
      dwell_d = '0;
      if (nv_act_found) begin
        state_d  = SHOW;
        active_d = nv_act_idx;
        select   = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      active_q  <= '0;
      resume_q  <= '0;
      dwell_q   <= '0;
      ucnt_q    <= '0;
      urg_q     <= '0;
      word_q    <= '0;
      showing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      resume_q  <= resume_d;
      dwell_q   <= dwell_d;
      ucnt_q    <= ucnt_d;
      urg_q     <= urg_lvl;
      showing_q <= (state_d != IDLE);
      if (state_d == IDLE) begin
        word_q <= '0;
      end else if (select || LIVE) begin
        word_q <= words[active_d];
      end
    end
  end

  assign column_1   = word_q[COL1_MSB:COL1_LSB];
  assign column_2   = word_q[COL2_MSB:COL2_LSB];
  assign column_3   = word_q[COL3_MSB:COL3_LSB];
  assign column_4   = word_q[COL4_MSB:COL4_LSB];
  assign active_src = active_q;
  assign showing    = showing_q;

endmodule

// File: tb/tb_debug_display_scheduler.sv
// Directed + randomized bench for debug_display_scheduler against a countdown-based reference model.
module tb_debug_display_scheduler;

  localparam int N = 4;
  localparam int D = 8;
  localparam int U = 16;
`ifdef DEBUG_DISPLAY_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N*32-1:0] src_data;
  logic [N-1:0]   src_valid;
  logic [N-1:0]   src_urgent;
  logic           advance;
  logic [7:0]     column_1, column_2, column_3, column_4;
  logic [1:0]     active_src;
  logic           showing;

  always #5 clk = ~clk;

  debug_display_scheduler #(
    .N_SRC(N), .DWELL_CYCLES(D), .URGENT_CYCLES(U)
  ) dut (
    .clk(clk), .rst(rst), .src_data(src_data), .src_valid(src_valid),
    .src_urgent(src_urgent), .advance(advance),
    .column_1(column_1), .column_2(column_2), .column_3(column_3), .column_4(column_4),
    .active_src(active_src), .showing(showing)
  );

  int checks = 0;
  int errors = 0;

  // Model: mode 0 idle, 1 rotating, 2 urgent; hold times kept as remaining-cycle countdowns.
  int          m_mode, m_idx, m_resume, m_left, m_uleft;
  logic [N-1:0] m_uprev;
  logic [31:0] m_word;
  bit          m_sel;

  function automatic int next_valid(input int base, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(base + k) % N]) return (base + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_resume = 0; m_left = 0; m_uleft = 0;
    m_uprev = '0; m_word = '0; m_sel = 1'b0;
  endtask

  task automatic model_pick(input int base);
    int n;
    n = next_valid(base, src_valid);
    if (n < 0) begin
      m_mode = 0;
    end else begin
      m_mode = 1; m_idx = n; m_left = D; m_sel = 1'b1;
    end
  endtask

  task automatic model_step();
    logic [N-1:0] lvl, ev;
    int u;
    lvl = src_urgent & src_valid;
    ev = lvl & ~m_uprev;
    m_uprev = lvl;
    m_sel = 1'b0;
    if (ev != 0) begin
      u = 0;
      while (!ev[u]) u++;
      if (m_mode != 2) m_resume = m_idx;
      m_mode = 2; m_idx = u; m_uleft = U; m_sel = 1'b1;
    end else begin
      case (m_mode)
        0: if (src_valid != 0) model_pick(m_idx);
        1: begin
          if (advance || !src_valid[m_idx] || m_left == 1) model_pick(m_idx);
          else m_left--;
        end
        default: begin
          if (advance) model_pick(m_idx);
          else if (!src_valid[m_idx] || m_uleft == 1) begin
            if (src_valid[m_resume]) begin
              m_mode = 1; m_idx = m_resume; m_left = D; m_sel = 1'b1;
            end else begin
              model_pick(m_resume);
            end
          end else m_uleft--;
        end
      endcase
    end
    if (m_mode == 0) m_word = '0;
    else if (m_sel || !SNAP) m_word = src_data[m_idx*32 +: 32];
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string where);
    chk({where, ".active_src"}, 32'(active_src), 32'(m_idx));
    chk({where, ".showing"}, 32'(showing), 32'(m_mode != 0));
    chk({where, ".columns"}, {column_1, column_2, column_3, column_4}, m_word);
  endtask

  task automatic tick(input string where);
    model_step();
    @(posedge clk);
    #1;
    check_outputs(where);
  endtask

  task automatic do_reset(input string where);
    rst = 1'b1;
    #1;
    model_reset();
    chk({where, ".rst_columns"}, {column_1, column_2, column_3, column_4}, 32'h0);
    chk({where, ".rst_active"}, 32'(active_src), 32'd0);
    chk({where, ".rst_showing"}, 32'(showing), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; src_data = '0; src_valid = '0; src_urgent = '0; advance = 1'b0;
    for (int i = 0; i < N; i++) src_data[i*32 +: 32] = $urandom;
    @(posedge clk);
    #1;
    do_reset("init");

    // Bring-up: single valid source 0 shows its word.
    src_data[31:0] = 32'hDEADBEEF;
    src_valid = 4'b0001;
    tick("bringup");
    chk("bringup.c1", 32'(column_1), 32'hDE);
    chk("bringup.c2", 32'(column_2), 32'hAD);
    chk("bringup.c3", 32'(column_3), 32'hBE);
    chk("bringup.c4", 32'(column_4), 32'hEF);

    // Reset in the middle of SHOW.
    src_valid = 4'b1111;
    repeat (5) tick("show1111");
    do_reset("midshow");

    // Rotation 1,3,1,3 with wrap.
    src_valid = 4'b1010;
    repeat (40) tick("rot1010");

    // Advance from src 1 with 1011, then with 0010.
    for (int i = 0; i < 20 && active_src != 2'd1; i++) tick("seek1");
    src_valid = 4'b1011; advance = 1'b1;
    tick("adv1011");
    advance = 1'b0;
    chk("adv1011.to3", 32'(active_src), 32'd3);
    repeat (3) tick("post_adv");
    src_valid = 4'b0010;
    repeat (3) tick("only1");
    advance = 1'b1;
    tick("adv0010");
    advance = 1'b0;
    chk("adv0010.stay1", 32'(active_src), 32'd1);
    repeat (10) tick("post_adv2");

    // Urgent preempt, retarget, resume.
    src_valid = 4'b0001;
    repeat (3) tick("only0");
    src_valid = 4'b0111;
    tick("valid0111");
    src_urgent = 4'b0110;
    tick("urg_entry");
    chk("urg_entry.src1", 32'(active_src), 32'd1);
    src_urgent = 4'b0010;
    repeat (4) tick("urg_hold");
    src_urgent = 4'b0110;
    tick("urg_retarget");
    chk("urg_retarget.src2", 32'(active_src), 32'd2);
    repeat (20) tick("urg_resume");
    src_urgent = 4'b0000;

    // Dropout of the only source.
    src_valid = 4'b0001;
    repeat (3) tick("pre_drop");
    src_valid = 4'b0000;
    tick("drop");
    chk("drop.showing", 32'(showing), 32'd0);
    chk("drop.columns", {column_1, column_2, column_3, column_4}, 32'h0);

    // Word change mid-dwell.
    src_data[31:0] = 32'h11223344;
    src_valid = 4'b0001;
    repeat (3) tick("snap_pre");
    src_data[31:0] = 32'h55667788;
    tick("snap_change");
    chk("snap_change.word", {column_1, column_2, column_3, column_4},
        SNAP ? 32'h11223344 : 32'h55667788);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(15) == 0) src_valid = 4'($urandom);
      if ($urandom_range(11) == 0) src_urgent = src_urgent ^ (4'b1 << $urandom_range(3));
      advance = ($urandom_range(19) == 0);
      if ($urandom_range(3) == 0) src_data[$urandom_range(3)*32 +: 32] = $urandom;
      if ($urandom_range(499) == 0) do_reset("rand_rst");
      else tick("rand");
    end
    advance = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
